mac_accumulator: RTL
====================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, signed operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default 48, signed accumulator/result width (ACC_WIDTH >= 2*DATA_WIDTH).
REQ-003 SHALL have parameter LEN_WIDTH, default 10, width of vector-length input.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin one dot product.
REQ-007 SHALL have port len  input  LEN_WIDTH  number of operand pairs; sampled with start.
REQ-008 SHALL have port bias  input  ACC_WIDTH  signed initial accumulator value; sampled with start.
REQ-009 SHALL have port in_valid  input  1  data_a/data_b pair valid.
REQ-010 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-011 SHALL have port data_a  input  DATA_WIDTH  signed operand A.
REQ-012 SHALL have port data_b  input  DATA_WIDTH  signed operand B.
REQ-013 SHALL have port result  output  ACC_WIDTH  signed dot-product result.
REQ-014 SHALL have port result_valid  output  1  result holds a completed value.
REQ-015 SHALL have port result_ready  input  1  consumer takes result.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port overflow  output  1  saturation occurred during the current/last operation.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-019 SHALL, in IDLE on start=1, load acc=bias, count=0, latch len; go to ACCUM if len!=0, else go to DONE with result=bias.
REQ-020 SHALL ignore start when not in IDLE (no restart, no state change).
REQ-021 SHALL drive in_ready=1 only in ACCUM; a pair is accepted when in_valid && in_ready.
REQ-022 SHALL, per accepted pair, compute full-precision signed product data_a*data_b (2*DATA_WIDTH bits), sign-extend to ACC_WIDTH, add to acc, increment count.
REQ-023 SHALL leave acc and count unchanged on ACCUM cycles with in_valid=0 (stalls of any length allowed).
REQ-024 SHALL saturate the sum to max positive (2^(ACC_WIDTH-1)-1) or max negative (-2^(ACC_WIDTH-1)) on signed overflow and set overflow=1; overflow sticky until next accepted start.
REQ-025 SHALL, when the accepted pair is number len (count==len-1), transition to DONE; result_valid=1 and result=final acc on the next cycle (latency 1 cycle after last accepted pair).
REQ-026 SHALL hold result and result_valid stable in DONE until result_ready=1; on that cycle return to IDLE, result_valid=0 next cycle.
REQ-027 SHALL keep result value unchanged after return to IDLE until the next DONE.
REQ-028 SHALL process a start asserted in the same cycle IDLE is re-entered only on the following cycle (start in DONE ignored even if result_ready=1).

Reset
REQ-029 SHALL, on reset=1 at a clock edge, force state=IDLE, acc=0, count=0, result=0, result_valid=0, in_ready=0, busy=0, overflow=0, regardless of current state (including mid-ACCUM and DONE).
REQ-030 SHALL give reset priority over start, in_valid and result_ready in the same cycle.

Verification
REQ-031 SHALL verify basic dot product: bias=0, len=3, pairs (2,3),(-4,5),(7,-1) back-to-back -> result=-21, result_valid one cycle after third pair, busy high throughout.
REQ-032 SHALL verify bias and stalls: bias=100, len=2, pairs (10,10),(−1,1) with 3 idle in_valid=0 cycles between -> result=199; in_ready high through stalls.
REQ-033 SHALL verify len=0: start with bias=-5 -> DONE next cycle, result=-5, no pairs accepted (in_ready stays 0).
REQ-034 SHALL verify saturation: ACC_WIDTH=48, bias=2^47-10, len=1, pair (4,4) -> result=2^47-1, overflow=1; next start clears overflow.
REQ-035 SHALL verify backpressure and reset: hold result_ready=0 for 5 cycles -> result stable; then reset mid-ACCUM (after 1 of 4 pairs) -> all outputs 0 next cycle, subsequent start runs cleanly.
REQ-036 SHALL verify start while busy is ignored: second start during ACCUM -> result equals first operation's value, count unaffected.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator: signed multiply-accumulate engine that computes one dot
// product per start request, seeded with a bias, with saturating accumulation.
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous active-high reset
//   start         one-cycle request to begin a dot product (honoured in IDLE only)
//   len           number of operand pairs, sampled with start
//   bias          signed initial accumulator value, sampled with start
//   in_valid      data_a/data_b pair valid
//   in_ready      pair accepted this cycle when in_valid is also high (ACCUM only)
//   data_a/b      signed operands
//   result        signed dot-product result, held until the next completion
//   result_valid  result holds a completed value (DONE)
//   result_ready  consumer takes the result
//   busy          high outside IDLE
//   overflow      sticky saturation flag, cleared by the next accepted start
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result keeps the last completed value
// ACCUM | accepting operand pairs until len pairs have been summed
// DONE  | result_valid high, waiting for result_ready
module mac_accumulator #(
    parameter int DATA_WIDTH = 18,
    parameter int ACC_WIDTH  = 48,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ACC_WIDTH-1:0]  bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [LEN_WIDTH-1:0]   count;
    logic [LEN_WIDTH-1:0]   len_q;

    logic signed [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   sum;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   sum_ovf;
    logic                   last_pair;

    // Operands are widened as signed values before the multiply so the
    // product keeps full precision; the signed cast then sign-extends it.
    assign prod     = PROD_WIDTH'($signed(data_a)) * PROD_WIDTH'($signed(data_b));
    assign prod_ext = ACC_WIDTH'(prod);
    assign sum      = acc + prod_ext;

    // Two's-complement overflow: addends share a sign that the sum lost.
    // The direction of saturation follows the sign of the addends.
    assign sum_ovf  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    assign acc_next = sum_ovf ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;

    // len_q is never zero while in ACCUM, so len_q-1 cannot wrap there.
    assign last_pair = (count == len_q - LEN_WIDTH'(1));

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            len_q        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= bias;
                        count    <= '0;
                        len_q    <= len;
                        overflow <= 1'b0;
                        if (len == '0) begin
                            result       <= bias;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        count <= count + LEN_WIDTH'(1);
                        if (sum_ovf) begin
                            overflow <= 1'b1;
                        end
                        if (last_pair) begin
                            result       <= acc_next;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; a start that
                    // coincides with the hand-off is dropped.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
